sfx_voice_player: RTL and testbench

- Two-voice sound-effect sample player; sits directly upstream of the speaker PWM counter stage.
- Takes that stage's 44 kHz square wave as its sample clock.
- On a trigger, fetches an effect header from the shared sample ROM, then streams samples from that ROM once per sample period.
- Mixes both voices into the 5-bit level the PWM stage consumes (valid range 0..27).

---
 rtl/sfx_voice_player.sv | 247 ++++++++++++++++++++++++
 tb/tb_sfx_voice_player.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/sfx_voice_player.sv
// Two-voice sound-effect sample player: header fetch on trigger, per-tick sample fetch, saturating mix.
// Define SFX_LOOP_EN to honour the header loop flag (len_hi[7]); otherwise every effect plays once.
module sfx_voice_player #(
    parameter int unsigned ADDR_W    = 14,
    parameter int unsigned LEVEL_MAX = 27
) (
    input  logic              Clk,
    input  logic              reset_n,
    input  logic              sample_clk,
    input  logic              trig_valid,
    input  logic [2:0]        trig_id,
    output logic              trig_ready,
    output logic              rom_rd,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [4:0]        sound_level,
    output logic [1:0]        voice_active
);

    localparam int unsigned LEN_W = 15;
    localparam int unsigned LVL_W = 5;
    localparam int unsigned HDR_W = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_START,
        S_FETCH0,
        S_FETCH1,
        S_MIX
    } state_e;

    state_e              state_q, state_d;
    logic                sclk_q;
    logic                tick_q, tick_d;
    logic                pend_q, pend_d;
    logic [2:0]          hcnt_q, hcnt_d;
    logic [2:0]          id_q, id_d;
    logic [HDR_W-1:0]    hdr_q, hdr_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ready_q, ready_d;
    logic [LVL_W-1:0]    level_q, level_d;
    logic [3:0]          nib0_q, nib0_d;
    logic                act1s_q, act1s_d;
    logic [1:0]          active_q, active_d;
    logic                steal_q, steal_d;
    logic [ADDR_W-1:0]   ptr_q [2];
    logic [ADDR_W-1:0]   ptr_d [2];
    logic [LEN_W-1:0]    cnt_q [2];
    logic [LEN_W-1:0]    cnt_d [2];
`ifdef SFX_LOOP_EN
    logic [ADDR_W-1:0]   lstart_q [2];
    logic [ADDR_W-1:0]   lstart_d [2];
    logic [LEN_W-1:0]    llen_q [2];
    logic [LEN_W-1:0]    llen_d [2];
    logic [1:0]          lflag_q, lflag_d;
`else
    logic                unused_loop_flag;
    assign unused_loop_flag = hdr_q[15];
`endif

    logic [ADDR_W-1:0]   hdr_start;
    logic [LEN_W-1:0]    hdr_len;
    logic                vsel;
    logic [LVL_W-1:0]    lvl_sum;

    assign hdr_start    = ADDR_W'(hdr_q[31:16]);
    assign hdr_len      = hdr_q[LEN_W-1:0];
    assign tick_d       = sample_clk & ~sclk_q;

    assign trig_ready   = ready_q;
    assign rom_rd       = rd_q;
    assign rom_addr     = addr_q;
    assign sound_level  = level_q;
    assign voice_active = active_q;

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        hcnt_d   = hcnt_q;
        id_d     = id_q;
        hdr_d    = hdr_q;
        rd_d     = 1'b0;
        addr_d   = addr_q;
        level_d  = level_q;
        nib0_d   = nib0_q;
        act1s_d  = act1s_q;
        active_d = active_q;
        steal_d  = steal_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
`ifdef SFX_LOOP_EN
        lstart_d = lstart_q;
        llen_d   = llen_q;
        lflag_d  = lflag_q;
`endif
        vsel     = 1'b0;
        lvl_sum  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (tick_q || pend_q) begin
                    state_d = S_FETCH0;
                    pend_d  = 1'b0;
                    rd_d    = 1'b1;
                    addr_d  = ptr_q[0];
                end else if (trig_valid && ready_q) begin
                    state_d = S_HDR;
                    id_d    = trig_id;
                    hcnt_d  = 3'd0;
                    rd_d    = 1'b1;
                    addr_d  = ADDR_W'({trig_id, 2'b00});
                end
            end
            S_HDR: begin
                if (tick_q) pend_d = 1'b1;
                if (hcnt_q != 3'd0) hdr_d = {hdr_q[HDR_W-9:0], rom_data};
                if (hcnt_q < 3'd3) begin
                    rd_d   = 1'b1;
                    addr_d = ADDR_W'({id_q, hcnt_q[1:0] + 2'd1});
                end
                if (hcnt_q == 3'd4) state_d = S_START;
                else                hcnt_d  = hcnt_q + 3'd1;
            end
            S_START: begin
                if (hdr_len != '0) begin
                    if (!active_q[0])      vsel = 1'b0;
                    else if (!active_q[1]) vsel = 1'b1;
                    else begin
                        vsel    = steal_q;
                        steal_d = ~steal_q;
                    end
                    active_d[vsel] = 1'b1;
                    ptr_d[vsel]    = hdr_start;
                    cnt_d[vsel]    = hdr_len;
`ifdef SFX_LOOP_EN
                    lstart_d[vsel] = hdr_start;
                    llen_d[vsel]   = hdr_len;
                    lflag_d[vsel]  = hdr_q[15];
`endif
                end
                // A tick deferred by the header fetch is serviced right away, after allocation.
                if (tick_q || pend_q) begin
                    state_d = S_FETCH0;
                    pend_d  = 1'b0;
                    rd_d    = 1'b1;
                    addr_d  = ptr_d[0];
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH0: begin
                rd_d    = 1'b1;
                addr_d  = ptr_q[1];
                state_d = S_FETCH1;
            end
            S_FETCH1: begin
                nib0_d  = active_q[0] ? rom_data[7:4] : 4'd0;
                act1s_d = active_q[1];
                for (int v = 0; v < 2; v++) begin
                    if (active_q[v]) begin
                        ptr_d[v] = ptr_q[v] + ADDR_W'(1);
                        cnt_d[v] = cnt_q[v] - LEN_W'(1);
                        if (cnt_q[v] == LEN_W'(1)) begin
`ifdef SFX_LOOP_EN
                            if (lflag_q[v]) begin
                                ptr_d[v] = lstart_q[v];
                                cnt_d[v] = llen_q[v];
                            end else begin
                                active_d[v] = 1'b0;
                            end
`else
                            active_d[v] = 1'b0;
`endif
                        end
                    end
                end
                state_d = S_MIX;
            end
            S_MIX: begin
                lvl_sum = LVL_W'(nib0_q) + (act1s_q ? LVL_W'(rom_data[7:4]) : LVL_W'(0));
                level_d = (lvl_sum > LVL_W'(LEVEL_MAX)) ? LVL_W'(LEVEL_MAX) : lvl_sum;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        ready_d = (state_d == S_IDLE) && !tick_d && !pend_d;
    end

    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            sclk_q   <= 1'b0;
            tick_q   <= 1'b0;
            pend_q   <= 1'b0;
            hcnt_q   <= '0;
            id_q     <= '0;
            hdr_q    <= '0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            ready_q  <= 1'b0;
            level_q  <= '0;
            nib0_q   <= '0;
            act1s_q  <= 1'b0;
            active_q <= '0;
            steal_q  <= 1'b0;
            for (int v = 0; v < 2; v++) begin
                ptr_q[v] <= '0;
                cnt_q[v] <= '0;
`ifdef SFX_LOOP_EN
                lstart_q[v] <= '0;
                llen_q[v]   <= '0;
`endif
            end
`ifdef SFX_LOOP_EN
            lflag_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            sclk_q   <= sample_clk;
            tick_q   <= tick_d;
            pend_q   <= pend_d;
            hcnt_q   <= hcnt_d;
            id_q     <= id_d;
            hdr_q    <= hdr_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            ready_q  <= ready_d;
            level_q  <= level_d;
            nib0_q   <= nib0_d;
            act1s_q  <= act1s_d;
            active_q <= active_d;
            steal_q  <= steal_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
`ifdef SFX_LOOP_EN
            lstart_q <= lstart_d;
            llen_q   <= llen_d;
            lflag_q  <= lflag_d;
`endif
        end
    end

endmodule

// File: tb/tb_sfx_voice_player.sv
// Directed bench for sfx_voice_player: behavioural ROM, level scoreboard, immediate-assertion checks.
module tb_sfx_voice_player;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_clk = 1'b0;
    logic        trig_valid = 1'b0;
    logic [2:0]  trig_id = 3'd0;
    logic        trig_ready;
    logic        rom_rd;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic [4:0]  sound_level;
    logic [1:0]  voice_active;

    logic [7:0]  rom [0:16383];
    logic [13:0] rd_log [$];
    logic [4:0]  exp_q [$];
    logic [4:0]  lvl_prev = 5'd0;
    int          vecs = 0;
    int          errs = 0;

    sfx_voice_player dut (
        .Clk          (clk),
        .reset_n      (reset_n),
        .sample_clk   (sample_clk),
        .trig_valid   (trig_valid),
        .trig_id      (trig_id),
        .trig_ready   (trig_ready),
        .rom_rd       (rom_rd),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .sound_level  (sound_level),
        .voice_active (voice_active)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: data one cycle after the read strobe; every read address is logged.
    always @(posedge clk) begin
        if (rom_rd) begin
            rom_data <= rom[rom_addr];
            rd_log.push_back(rom_addr);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vecs++;
        assert (obs === expv) else begin
            errs++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [4:0] e;
        if (exp_q.size() == 0) begin
            vecs++;
            errs++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(sound_level), 32'(e));
            lvl_prev = e;
        end
    endtask

    task automatic do_tick(input logic [4:0] expv, input string tag);
        exp_q.push_back(expv);
        @(negedge clk) sample_clk = 1'b1;
        @(negedge clk) sample_clk = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_hold"}, 32'(sound_level), 32'(lvl_prev));
        @(negedge clk);
        pop_chk(tag);
        repeat (2) @(negedge clk);
    endtask

    task automatic trig(input logic [2:0] id);
        @(negedge clk);
        trig_valid = 1'b1;
        trig_id    = id;
        chk("trig_ready_idle", 32'(trig_ready), 32'd1);
        @(negedge clk);
        trig_valid = 1'b0;
        chk("trig_ready_busy", 32'(trig_ready), 32'd0);
        repeat (6) @(negedge clk);
        chk("trig_ready_back", 32'(trig_ready), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk) reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        lvl_prev = 5'd0;
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic set_hdr(input int id, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
        rom[4*id+0] = b0;
        rom[4*id+1] = b1;
        rom[4*id+2] = b2;
        rom[4*id+3] = b3;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) rom[i] = 8'h00;
        set_hdr(0, 8'h08, 8'h00, 8'h00, 8'h64);
        set_hdr(1, 8'h07, 8'h00, 8'h00, 8'h00);
        set_hdr(2, 8'h01, 8'h00, 8'h00, 8'h03);
        set_hdr(3, 8'h02, 8'h00, 8'h00, 8'h14);
        set_hdr(4, 8'h03, 8'h00, 8'h00, 8'h14);
        set_hdr(5, 8'h04, 8'h00, 8'h00, 8'h14);
        set_hdr(6, 8'h05, 8'h00, 8'h00, 8'h14);
        set_hdr(7, 8'h06, 8'h00, 8'h00, 8'h01);
        rom[14'h100] = 8'h50;
        rom[14'h101] = 8'hF0;
        rom[14'h102] = 8'h20;
        for (int i = 0; i < 20; i++) begin
            rom[14'h200 + i] = 8'hF0;
            rom[14'h300 + i] = 8'hD0;
            rom[14'h400 + i] = 8'h10;
            rom[14'h500 + i] = 8'h20;
        end
        rom[14'h600] = 8'h90;
        for (int i = 0; i < 100; i++) rom[14'h800 + i] = 8'h30;

        // Reset values while held.
        repeat (3) @(negedge clk);
        chk("rst_level", 32'(sound_level), 32'd0);
        chk("rst_active", 32'(voice_active), 32'd0);
        chk("rst_rom_rd", 32'(rom_rd), 32'd0);
        chk("rst_rom_addr", 32'(rom_addr), 32'd0);
        chk("rst_trig_ready", 32'(trig_ready), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        rd_log.delete();

        // Idle ticks: silent, two reads per tick.
        for (int t = 0; t < 10; t++) do_tick(5'd0, "idle_lvl");
        chk("idle_reads", 32'(rd_log.size()), 32'd20);
        chk("idle_active", 32'(voice_active), 32'd0);
        chk("idle_ready", 32'(trig_ready), 32'd1);

        // Single effect id=2: header reads 8..11, levels 5,15,2 then silence.
        rd_log.delete();
        trig(3'd2);
        chk("hdr_nreads", 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            chk("hdr_addr", 32'(rd_log[i]), 32'(8 + i));
        chk("one_active", 32'(voice_active), 32'd1);
        do_tick(5'd5, "one_s0");
        do_tick(5'd15, "one_s1");
        do_tick(5'd2, "one_s2");
        chk("one_done", 32'(voice_active), 32'd0);
        do_tick(5'd0, "one_after");

        // Saturation and voice stealing order.
        trig(3'd3);
        trig(3'd4);
        chk("two_active", 32'(voice_active), 32'd3);
        do_tick(5'd27, "sat");
        trig(3'd5);
        do_tick(5'd14, "steal_v0");
        trig(3'd6);
        do_tick(5'd3, "steal_v1");
        chk("steal_active", 32'(voice_active), 32'd3);
        do_reset();

        // Trigger accepted two cycles before a tick: tick deferred until after allocation.
        @(negedge clk);
        trig_valid = 1'b1;
        trig_id    = 3'd7;
        chk("pend_ready", 32'(trig_ready), 32'd1);
        @(negedge clk);
        trig_valid = 1'b0;
        @(negedge clk);
        sample_clk = 1'b1;
        exp_q.push_back(5'd9);
        @(negedge clk);
        sample_clk = 1'b0;
        repeat (6) @(negedge clk);
        chk("pend_hold", 32'(sound_level), 32'(lvl_prev));
        @(negedge clk);
        pop_chk("pend_lvl");
        repeat (2) @(negedge clk);
        chk("pend_done", 32'(voice_active), 32'd0);
        do_tick(5'd0, "pend_after");

        // Zero-length header is consumed without touching voices.
        trig(3'd0);
        chk("len0_pre", 32'(voice_active), 32'd1);
        trig(3'd1);
        chk("len0_post", 32'(voice_active), 32'd1);
        do_tick(5'd3, "len0_lvl");

        // Asynchronous reset in the middle of a sample fetch.
        @(negedge clk) sample_clk = 1'b1;
        @(negedge clk) sample_clk = 1'b0;
        @(negedge clk);
        chk("mid_rd", 32'(rom_rd), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_level", 32'(sound_level), 32'd0);
        chk("mid_active", 32'(voice_active), 32'd0);
        chk("mid_rom_rd", 32'(rom_rd), 32'd0);
        chk("mid_rom_addr", 32'(rom_addr), 32'd0);
        chk("mid_ready", 32'(trig_ready), 32'd0);
        @(negedge clk) reset_n = 1'b1;
        lvl_prev = 5'd0;
        exp_q.delete();
        repeat (2) @(negedge clk);

        // Loop-flagged header, length 2.
        set_hdr(2, 8'h0A, 8'h00, 8'h80, 8'h02);
        rom[14'hA00] = 8'h40;
        rom[14'hA01] = 8'h70;
        rom[14'hA02] = 8'hE0;
        trig(3'd2);
        do_tick(5'd4, "loop_s0");
        do_tick(5'd7, "loop_s1");
`ifdef SFX_LOOP_EN
        do_tick(5'd4, "loop_s0b");
        do_tick(5'd7, "loop_s1b");
        chk("loop_active", 32'(voice_active), 32'd1);
`else
        do_tick(5'd0, "loop_s0b");
        do_tick(5'd0, "loop_s1b");
        chk("loop_active", 32'(voice_active), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
